uart_modport: RTL and testbench

Full-duplex UART with runtime-configurable baud rate, parity and stop bits. The transmitter takes parallel bytes through a valid/ready handshake and serialises them on `uart_tx`. The receiver deserialises `uart_rx` and reports each byte with a one-cycle valid strobe and an error flag. It sits between the bus-side data path and the external serial pins, and is bound to the DUT modport of the UART interface.

---
 rtl/uart_pkg.sv | 37 +++
 rtl/uart_modport_if.sv | 27 ++
 rtl/uart_baud_gen.sv | 19 +
 rtl/uart_modport.sv | 298 +++++++++++++++++++++++++++++
 tb/tb_uart_modport.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the uart_modport block.
package uart_pkg;

    localparam int unsigned MIN_DIV = 4;

    typedef enum logic [1:0] {
        PAR_NONE,
        PAR_EVEN,
        PAR_ODD
    } parity_e;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_e;

    // 2'b11 is a second encoding of "no parity".
    function automatic parity_e decode_parity(input logic [1:0] mode);
        case (mode)
            2'b01:   return PAR_EVEN;
            2'b10:   return PAR_ODD;
            default: return PAR_NONE;
        endcase
    endfunction

endpackage

// File: rtl/uart_modport_if.sv
// Bus-side and pin-side signals of the UART; dut is the block side, master drives it.
interface uart_modport_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic [31:0]           baud_rate;
    logic [1:0]            parity_mode;
    logic                  stop_bits;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic                  tx_done;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic                  rx_error;
    logic                  uart_tx;
    logic                  uart_rx;

    modport dut (
        input  baud_rate, parity_mode, stop_bits, tx_data, tx_valid, uart_rx,
        output tx_ready, tx_done, rx_data, rx_valid, rx_error, uart_tx
    );

    modport master (
        output baud_rate, parity_mode, stop_bits, tx_data, tx_valid, uart_rx,
        input  tx_ready, tx_done, rx_data, rx_valid, rx_error, uart_tx
    );
endinterface

// File: rtl/uart_baud_gen.sv
// Bit period in clk cycles: CLK_FREQ / baud_rate, never below MIN_DIV (baud 0 included).
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50_000_000
) (
    input  logic [31:0] baud_rate,
    output logic [31:0] div
);
    logic [31:0] quot;

    always_comb begin
        quot = '0;
        if (baud_rate != '0) begin
            quot = CLK_FREQ / baud_rate;
        end
        div = (quot < MIN_DIV) ? MIN_DIV : quot;
    end
endmodule

// File: rtl/uart_modport.sv
// Full-duplex UART: TX and RX FSMs with down-counting bit timers sharing one baud divider.
// state     | meaning
// IDLE      | line idle, waiting for handshake (TX) or falling edge (RX)
// START     | start bit; RX re-checks the line at half a bit
// DATA      | data bits, LSB first
// PARITY    | parity bit, skipped when parity is off
// STOP      | stop bit(s); RX samples only the first
module uart_modport
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CLK_FREQ   = 50_000_000
) (
    input  logic         clk,
    input  logic         rst_n,
    uart_modport_if.dut  bus
);
    localparam int unsigned BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    logic [31:0] div;

    uart_baud_gen #(.CLK_FREQ(CLK_FREQ)) u_baud_gen (
        .baud_rate (bus.baud_rate),
        .div       (div)
    );

    tx_state_e             tx_state_q, tx_state_d;
    logic [31:0]           tx_cnt_q, tx_cnt_d;
    logic [31:0]           tx_div_q, tx_div_d;
    logic [BW-1:0]         tx_bits_q, tx_bits_d;
    logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
    parity_e               tx_par_q, tx_par_d;
    logic                  tx_par_bit_q, tx_par_bit_d;
    logic                  tx_stop2_q, tx_stop2_d;
    logic                  tx_extra_stop_q, tx_extra_stop_d;
    logic                  uart_tx_q, uart_tx_d;
    logic                  tx_done_q, tx_done_d;
    parity_e               tx_par_in;

    always_comb begin
        tx_state_d      = tx_state_q;
        tx_cnt_d        = tx_cnt_q;
        tx_div_d        = tx_div_q;
        tx_bits_d       = tx_bits_q;
        tx_shift_d      = tx_shift_q;
        tx_par_d        = tx_par_q;
        tx_par_bit_d    = tx_par_bit_q;
        tx_stop2_d      = tx_stop2_q;
        tx_extra_stop_d = tx_extra_stop_q;
        uart_tx_d       = uart_tx_q;
        tx_done_d       = 1'b0;
        tx_par_in       = decode_parity(bus.parity_mode);

        case (tx_state_q)
            TX_IDLE: begin
                if (bus.tx_valid) begin
                    tx_state_d   = TX_START;
                    tx_div_d     = div;
                    tx_cnt_d     = div - 32'd1;
                    tx_shift_d   = bus.tx_data;
                    tx_par_d     = tx_par_in;
                    tx_par_bit_d = (^bus.tx_data) ^ (tx_par_in == PAR_ODD);
                    tx_stop2_d   = bus.stop_bits;
                    uart_tx_d    = 1'b0;
                end
            end
            TX_START: begin
                if (tx_cnt_q == '0) begin
                    tx_state_d = TX_DATA;
                    tx_cnt_d   = tx_div_q - 32'd1;
                    tx_bits_d  = LAST_BIT;
                    uart_tx_d  = tx_shift_q[0];
                end else begin
                    tx_cnt_d = tx_cnt_q - 32'd1;
                end
            end
            TX_DATA: begin
                if (tx_cnt_q == '0) begin
                    tx_cnt_d = tx_div_q - 32'd1;
                    if (tx_bits_q == '0) begin
                        if (tx_par_q != PAR_NONE) begin
                            tx_state_d = TX_PARITY;
                            uart_tx_d  = tx_par_bit_q;
                        end else begin
                            tx_state_d      = TX_STOP;
                            uart_tx_d       = 1'b1;
                            tx_extra_stop_d = tx_stop2_q;
                        end
                    end else begin
                        tx_bits_d  = tx_bits_q - 1'b1;
                        tx_shift_d = tx_shift_q >> 1;
                        uart_tx_d  = tx_shift_d[0];
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q - 32'd1;
                end
            end
            TX_PARITY: begin
                if (tx_cnt_q == '0) begin
                    tx_state_d      = TX_STOP;
                    tx_cnt_d        = tx_div_q - 32'd1;
                    uart_tx_d       = 1'b1;
                    tx_extra_stop_d = tx_stop2_q;
                end else begin
                    tx_cnt_d = tx_cnt_q - 32'd1;
                end
            end
            TX_STOP: begin
                if (tx_cnt_q == '0) begin
                    if (tx_extra_stop_q) begin
                        tx_extra_stop_d = 1'b0;
                        tx_cnt_d        = tx_div_q - 32'd1;
                    end else begin
                        tx_state_d = TX_IDLE;
                        tx_done_d  = 1'b1;
                    end
                end else begin
                    tx_cnt_d = tx_cnt_q - 32'd1;
                end
            end
            default: begin
                tx_state_d = TX_IDLE;
                uart_tx_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_state_q      <= TX_IDLE;
            tx_cnt_q        <= '0;
            tx_div_q        <= MIN_DIV;
            tx_bits_q       <= '0;
            tx_shift_q      <= '0;
            tx_par_q        <= PAR_NONE;
            tx_par_bit_q    <= 1'b0;
            tx_stop2_q      <= 1'b0;
            tx_extra_stop_q <= 1'b0;
            uart_tx_q       <= 1'b1;
            tx_done_q       <= 1'b0;
        end else begin
            tx_state_q      <= tx_state_d;
            tx_cnt_q        <= tx_cnt_d;
            tx_div_q        <= tx_div_d;
            tx_bits_q       <= tx_bits_d;
            tx_shift_q      <= tx_shift_d;
            tx_par_q        <= tx_par_d;
            tx_par_bit_q    <= tx_par_bit_d;
            tx_stop2_q      <= tx_stop2_d;
            tx_extra_stop_q <= tx_extra_stop_d;
            uart_tx_q       <= uart_tx_d;
            tx_done_q       <= tx_done_d;
        end
    end

    rx_state_e             rx_state_q, rx_state_d;
    logic                  rx_s1_q, rx_s2_q, rx_prev_q;
    logic [31:0]           rx_cnt_q, rx_cnt_d;
    logic [31:0]           rx_div_q, rx_div_d;
    logic [BW-1:0]         rx_bits_q, rx_bits_d;
    logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
    parity_e               rx_par_q, rx_par_d;
    logic                  rx_acc_q, rx_acc_d;
    logic                  rx_par_bad_q, rx_par_bad_d;
    logic                  rx_stop_bad_q, rx_stop_bad_d;
    logic                  rx_fin_q, rx_fin_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  rx_error_q, rx_error_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;

    always_comb begin
        rx_state_d    = rx_state_q;
        rx_cnt_d      = rx_cnt_q;
        rx_div_d      = rx_div_q;
        rx_bits_d     = rx_bits_q;
        rx_shift_d    = rx_shift_q;
        rx_par_d      = rx_par_q;
        rx_acc_d      = rx_acc_q;
        rx_par_bad_d  = rx_par_bad_q;
        rx_stop_bad_d = rx_stop_bad_q;
        rx_fin_d      = 1'b0;
        rx_valid_d    = rx_fin_q;
        rx_error_d    = rx_error_q;
        rx_data_d     = rx_data_q;

        // Result is published one cycle after the stop-bit sample.
        if (rx_fin_q) begin
            rx_data_d  = rx_shift_q;
            rx_error_d = rx_par_bad_q | rx_stop_bad_q;
        end

        case (rx_state_q)
            RX_IDLE: begin
                if (rx_prev_q && !rx_s2_q) begin
                    rx_state_d = RX_START;
                    rx_div_d   = div;
                    rx_cnt_d   = (div >> 1) - 32'd2;
                    rx_par_d   = decode_parity(bus.parity_mode);
                end
            end
            RX_START: begin
                if (rx_cnt_q == '0) begin
                    if (rx_s2_q) begin
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_state_d   = RX_DATA;
                        rx_cnt_d     = rx_div_q - 32'd1;
                        rx_bits_d    = LAST_BIT;
                        rx_acc_d     = 1'b0;
                        rx_par_bad_d = 1'b0;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - 32'd1;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == '0) begin
                    rx_cnt_d   = rx_div_q - 32'd1;
                    rx_shift_d = DATA_WIDTH'({rx_s2_q, rx_shift_q} >> 1);
                    rx_acc_d   = rx_acc_q ^ rx_s2_q;
                    if (rx_bits_q == '0) begin
                        rx_state_d = (rx_par_q != PAR_NONE) ? RX_PARITY : RX_STOP;
                    end else begin
                        rx_bits_d = rx_bits_q - 1'b1;
                    end
                end else begin
                    rx_cnt_d = rx_cnt_q - 32'd1;
                end
            end
            RX_PARITY: begin
                if (rx_cnt_q == '0) begin
                    rx_state_d   = RX_STOP;
                    rx_cnt_d     = rx_div_q - 32'd1;
                    rx_par_bad_d = rx_acc_q ^ rx_s2_q ^ (rx_par_q == PAR_ODD);
                end else begin
                    rx_cnt_d = rx_cnt_q - 32'd1;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == '0) begin
                    rx_state_d    = RX_IDLE;
                    rx_stop_bad_d = ~rx_s2_q;
                    rx_fin_d      = 1'b1;
                end else begin
                    rx_cnt_d = rx_cnt_q - 32'd1;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1_q       <= 1'b1;
            rx_s2_q       <= 1'b1;
            rx_prev_q     <= 1'b1;
            rx_state_q    <= RX_IDLE;
            rx_cnt_q      <= '0;
            rx_div_q      <= MIN_DIV;
            rx_bits_q     <= '0;
            rx_shift_q    <= '0;
            rx_par_q      <= PAR_NONE;
            rx_acc_q      <= 1'b0;
            rx_par_bad_q  <= 1'b0;
            rx_stop_bad_q <= 1'b0;
            rx_fin_q      <= 1'b0;
            rx_valid_q    <= 1'b0;
            rx_error_q    <= 1'b0;
            rx_data_q     <= '0;
        end else begin
            rx_s1_q       <= bus.uart_rx;
            rx_s2_q       <= rx_s1_q;
            rx_prev_q     <= rx_s2_q;
            rx_state_q    <= rx_state_d;
            rx_cnt_q      <= rx_cnt_d;
            rx_div_q      <= rx_div_d;
            rx_bits_q     <= rx_bits_d;
            rx_shift_q    <= rx_shift_d;
            rx_par_q      <= rx_par_d;
            rx_acc_q      <= rx_acc_d;
            rx_par_bad_q  <= rx_par_bad_d;
            rx_stop_bad_q <= rx_stop_bad_d;
            rx_fin_q      <= rx_fin_d;
            rx_valid_q    <= rx_valid_d;
            rx_error_q    <= rx_error_d;
            rx_data_q     <= rx_data_d;
        end
    end

    assign bus.uart_tx  = uart_tx_q;
    assign bus.tx_ready = (tx_state_q == TX_IDLE);
    assign bus.tx_done  = tx_done_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.rx_error = rx_error_q;
    assign bus.rx_data  = rx_data_q;

endmodule

// File: tb/tb_uart_modport.sv
// Bench for uart_modport: directed frames, expectations queued at issue time and checked by monitors.
module tb_uart_modport;
    import uart_pkg::*;

    localparam int DW  = 8;
    localparam int CLK = 50_000_000;

    logic clk = 1'b0;
    logic rst_n;
    logic lb;
    logic rx_drv;

    always #5 clk = ~clk;

    uart_modport_if #(.DATA_WIDTH(DW)) bus ();
    assign bus.uart_rx = lb ? bus.uart_tx : rx_drv;

    uart_modport #(.DATA_WIDTH(DW), .CLK_FREQ(CLK)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [7:0] data;
        logic       err;
    } rx_exp_t;

    rx_exp_t rx_q[$];
    int      tx_len_q[$];
    int      n_cmp = 0;
    int      n_bad = 0;
    int      cyc = 0;
    int      rx_seen = 0;
    int      last_rx_cyc = 0;
    int      tx_fall = 0;
    logic    prev_ready = 1'b1;
    rx_exp_t mon_rx;
    int      mon_len;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every rx_valid and tx_done is matched against the oldest queued expectation.
    always @(negedge clk) begin
        if (bus.rx_valid) begin
            rx_seen++;
            last_rx_cyc = cyc;
            n_cmp++;
            if (rx_q.size() == 0) begin
                n_bad++;
                $display("FAIL rx_unexpected: rx_valid with data %0h, no frame expected", bus.rx_data);
            end else begin
                mon_rx = rx_q.pop_front();
                chk("rx_data", bus.rx_data, mon_rx.data);
                chk("rx_error", bus.rx_error, mon_rx.err);
            end
        end
        if (prev_ready && !bus.tx_ready) tx_fall = cyc;
        if (bus.tx_done) begin
            n_cmp++;
            if (tx_len_q.size() == 0) begin
                n_bad++;
                $display("FAIL tx_done_unexpected: tx_done with no frame expected");
            end else begin
                mon_len = tx_len_q.pop_front();
                chk("tx_frame_len", cyc - tx_fall, mon_len);
                chk("tx_ready_at_done", bus.tx_ready, 1);
            end
        end
        prev_ready = bus.tx_ready;
    end

    task automatic send(input logic [7:0] d, input int len, input bit push_rx);
        int budget = 2000;
        @(negedge clk);
        while (!bus.tx_ready && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL tx_ready_wait: tx_ready still 0 after timeout");
        end
        bus.tx_data  = d;
        bus.tx_valid = 1'b1;
        if (len > 0) tx_len_q.push_back(len);
        if (push_rx) rx_q.push_back('{data: d, err: 1'b0});
        @(posedge clk);
        #1 bus.tx_valid = 1'b0;
    endtask

    task automatic drive_frame(input logic [7:0] d, input bit has_par, input logic par_bit,
                               input logic stop_val, input int bit_cyc, output int fall);
        @(posedge clk);
        #1 rx_drv = 1'b0;
        fall = cyc;
        repeat (bit_cyc) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            #1 rx_drv = d[i];
            repeat (bit_cyc) @(posedge clk);
        end
        if (has_par) begin
            #1 rx_drv = par_bit;
            repeat (bit_cyc) @(posedge clk);
        end
        #1 rx_drv = stop_val;
        repeat (bit_cyc) @(posedge clk);
        #1 rx_drv = 1'b1;
        repeat (bit_cyc) @(posedge clk);
    endtask

    task automatic wait_drain();
        int budget = 3000;
        @(negedge clk);
        while ((rx_q.size() != 0 || tx_len_q.size() != 0 || !bus.tx_ready) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        n_cmp++;
        if (budget == 0) begin
            n_bad++;
            $display("FAIL drain: %0d rx and %0d tx expectations pending after timeout",
                     rx_q.size(), tx_len_q.size());
        end
        repeat (5) @(negedge clk);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] pat;
        int         fall;
        int         n0;

        rst_n           = 1'b0;
        lb              = 1'b0;
        rx_drv          = 1'b1;
        bus.tx_valid    = 1'b0;
        bus.tx_data     = '0;
        bus.baud_rate   = 32'd5_000_000;
        bus.parity_mode = 2'b00;
        bus.stop_bits   = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_uart_tx", bus.uart_tx, 1);
        chk("rst_tx_ready", bus.tx_ready, 1);
        chk("rst_tx_done", bus.tx_done, 0);
        chk("rst_rx_valid", bus.rx_valid, 0);
        chk("rst_rx_error", bus.rx_error, 0);
        chk("rst_rx_data", bus.rx_data, 0);
        rst_n = 1'b1;

        // 0xA5, D=10, no parity, 1 stop, looped back
        lb  = 1'b1;
        pat = 10'b1101001010;
        send(8'hA5, 100, 1'b1);
        repeat (6) @(posedge clk);
        for (int k = 0; k < 10; k++) begin
            #1 chk($sformatf("tx_bit%0d", k), bus.uart_tx, pat[k]);
            repeat (10) @(posedge clk);
        end
        wait_drain();

        // even parity, two stop bits, back to back
        bus.parity_mode = 2'b01;
        bus.stop_bits   = 1'b1;
        send(8'h00, 120, 1'b1);
        send(8'hFF, 120, 1'b1);
        send(8'h3C, 120, 1'b1);
        wait_drain();

        // odd parity: 0x55 has four ones, so the correct parity bit is 1
        lb              = 1'b0;
        bus.parity_mode = 2'b10;
        bus.stop_bits   = 1'b0;
        rx_q.push_back('{data: 8'h55, err: 1'b1});
        drive_frame(8'h55, 1'b1, 1'b0, 1'b1, 10, fall);
        rx_q.push_back('{data: 8'h55, err: 1'b0});
        drive_frame(8'h55, 1'b1, 1'b1, 1'b1, 10, fall);
        wait_drain();

        // framing error then a good frame; latency = 2 + 5 + 9*10 + 1
        bus.parity_mode = 2'b00;
        rx_q.push_back('{data: 8'h81, err: 1'b1});
        drive_frame(8'h81, 1'b0, 1'b0, 1'b0, 10, fall);
        rx_q.push_back('{data: 8'h42, err: 1'b0});
        drive_frame(8'h42, 1'b0, 1'b0, 1'b1, 10, fall);
        wait_drain();
        chk("rx_latency", last_rx_cyc - fall, 98);

        // 3-cycle glitch: start is detected, then rejected at the half-bit check
        n0 = rx_seen;
        @(posedge clk);
        #1 rx_drv = 1'b0;
        repeat (3) @(posedge clk);
        #1 rx_drv = 1'b1;
        repeat (2) @(posedge clk);
        #1 chk("glitch_start_seen", 32'(dut.rx_state_q), 32'(RX_START));
        repeat (30) @(posedge clk);
        #1 chk("glitch_no_valid", rx_seen, n0);
        chk("glitch_rx_idle", 32'(dut.rx_state_q), 32'(RX_IDLE));

        // divider clamp and integer division
        lb            = 1'b1;
        bus.baud_rate = 32'd0;
        send(8'h5A, 40, 1'b1);
        wait_drain();
        bus.baud_rate = 32'd20_000_000;
        send(8'hC3, 40, 1'b1);
        wait_drain();
        bus.baud_rate = 32'd3_000_000;
        send(8'h96, 160, 1'b1);
        wait_drain();

        // reset during data bit 3 of 0x77 (a 0 on the line)
        bus.baud_rate = 32'd5_000_000;
        send(8'h77, 0, 1'b0);
        repeat (45) @(posedge clk);
        #1 chk("pre_reset_tx_low", bus.uart_tx, 0);
        #2 rst_n = 1'b0;
        #1 chk("reset_uart_tx", bus.uart_tx, 1);
        chk("reset_tx_ready", bus.tx_ready, 1);
        chk("reset_rx_data", bus.rx_data, 0);
        repeat (5) @(posedge clk);
        #1 chk("reset_tx_done", bus.tx_done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        send(8'h11, 100, 1'b1);
        wait_drain();

        chk("rx_queue_empty", rx_q.size(), 0);
        chk("tx_queue_empty", tx_len_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
